// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: buffers A/B, clears the PE array, feeds skewed rows/columns, captures C = A x B mod 256.
module systolic_seq_ctrl #(
  parameter int Size = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic                        ld_sel,
  input  logic [2*$clog2(Size)-1:0]   ld_addr,
  input  logic [7:0]                  ld_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        arr_reset,
  output logic [Size*8-1:0]           arr_ab,
  output logic [Size*8-1:0]           arr_bb,
  input  logic [Size*Size*8-1:0]      arr_pab,
  output logic                        res_valid,
  output logic [Size*Size*8-1:0]      res_data,
  output logic                        done
);
  localparam int CW = $clog2(3*Size);
  localparam logic [CW-1:0] LAST = CW'(3*Size-3);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [Size*Size*8-1:0] a_q, b_q, res_q;
  logic valid_q, done_q, idle;
  int k;
  assign idle      = state_q == IDLE || state_q == DONE;
  assign ld_ready  = idle & ~reset;
  assign busy      = ~idle & ~reset;
  assign arr_reset = reset | (state_q == CLEAR);
  assign res_valid = valid_q;
  assign res_data  = res_q;
  assign done      = done_q;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE, DONE: state_d = start ? CLEAR : state_q;
      CLEAR: begin
        state_d = FEED;
        step_d  = '0;
      end
      FEED: begin
        step_d  = step_q + CW'(1);
        state_d = step_q == LAST ? CAPTURE : FEED;
      end
      CAPTURE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // row m / column m see element k = t-m, giving the diagonal skew
  always_comb begin
    arr_ab = '0;
    arr_bb = '0;
    k = 0;
    for (int i = 0; i < Size; i++) begin
      k = int'(step_q) - i;
      if (state_q == FEED && k >= 0 && k < Size) begin
        arr_ab[i*8 +: 8] = a_q[(i*Size+k)*8 +: 8];
        arr_bb[i*8 +: 8] = b_q[(k*Size+i)*8 +: 8];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= state_q == CAPTURE;
      if (state_q == CAPTURE) begin
        res_q   <= arr_pab;
        valid_q <= 1'b1;
      end else if (state_q == DONE && start) begin
        valid_q <= 1'b0;
      end
      if (ld_ready && ld_valid) begin
        if (ld_sel) b_q[{ld_addr, 3'b000} +: 8] <= ld_data;
        else        a_q[{ld_addr, 3'b000} +: 8] <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: random/directed runs against a matrix-product model, with a PE-array model driving arr_pab.
module tb_systolic_seq_ctrl;
  localparam int S = 4;
  logic clk = 0, reset = 1, ld_valid = 0, ld_sel = 0, start = 0;
  logic [3:0] ld_addr = 0;
  logic [7:0] ld_data = 0;
  logic ld_ready, busy, arr_reset, res_valid, done;
  logic [S*8-1:0] arr_ab, arr_bb;
  logic [S*S*8-1:0] arr_pab, res_data;
  systolic_seq_ctrl #(.Size(S)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .busy(busy), .arr_reset(arr_reset),
    .arr_ab(arr_ab), .arr_bb(arr_bb), .arr_pab(arr_pab), .res_valid(res_valid),
    .res_data(res_data), .done(done)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // output-stationary PE array: a flows right, b flows down, acc keeps 16 bits
  logic [7:0] pa [S][S], pb [S][S];
  logic [15:0] acc [S][S];
  always @(posedge clk) begin
    for (int m = 0; m < S; m++)
      for (int n = 0; n < S; n++) begin
        logic [7:0] ain, bin;
        ain = arr_ab[m*8 +: 8];
        bin = arr_bb[n*8 +: 8];
        if (n > 0) ain = pa[m][n-1];
        if (m > 0) bin = pb[m-1][n];
        if (arr_reset) begin
          pa[m][n] <= 0; pb[m][n] <= 0; acc[m][n] <= 0;
        end else begin
          pa[m][n] <= ain; pb[m][n] <= bin; acc[m][n] <= acc[m][n] + 16'(ain * bin);
        end
      end
  end
  always_comb begin
    arr_pab = '0;
    for (int m = 0; m < S; m++)
      for (int n = 0; n < S; n++) arr_pab[(m*S+n)*8 +: 8] = acc[m][n][7:0];
  end
  int ma [S*S], mb [S*S];
  typedef struct {logic [S*S*8-1:0] data; int cyc;} exp_t;
  exp_t q[$];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [S*S*8-1:0] golden();
    logic [S*S*8-1:0] g;
    g = '0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < S; i++) s += ma[r*S+i] * mb[i*S+c];
        g[(r*S+c)*8 +: 8] = 8'(s % 256);
      end
    return g;
  endfunction
  logic done_prev = 0;
  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_expected", q.size() != 0, 1);
      chk("done_pulse", done_prev, 0);
      chk("valid_with_done", res_valid, 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", res_data, e.data);
        chk("latency", cyc, e.cyc);
      end
    end
    done_prev <= done;
  end
  task automatic load(input bit sel, input int addr, input logic [7:0] d, input bit acc_ok);
    ld_valid = 1; ld_sel = sel; ld_addr = 4'(addr); ld_data = d;
    chk("ld_ready", ld_ready, acc_ok);
    if (acc_ok) begin
      if (sel) mb[addr] = int'(d);
      else ma[addr] = int'(d);
    end
    @(negedge clk);
    ld_valid = 0;
  endtask
  task automatic run(input bit with_ld, input bit sel, input int addr, input logic [7:0] d);
    start = 1;
    if (with_ld) begin
      ld_valid = 1; ld_sel = sel; ld_addr = 4'(addr); ld_data = d;
      if (sel) mb[addr] = int'(d);
      else ma[addr] = int'(d);
    end
    q.push_back('{golden(), cyc + 13});
    @(negedge clk);
    start = 0; ld_valid = 0;
    chk("valid_clear", res_valid, 0);
    chk("busy_run", busy, 1);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("run_timeout", q.size(), 0);
    @(negedge clk);
  endtask
  task automatic load_rand();
    for (int i = 0; i < S*S; i++) load(0, i, 8'($urandom), 1);
    for (int i = 0; i < S*S; i++) load(1, i, 8'($urandom), 1);
  endtask
  initial begin
    logic [S*S*8-1:0] last;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_arr_reset", arr_reset, 1);
    chk("rst_arr_ab", arr_ab, 0);
    chk("rst_arr_bb", arr_bb, 0);
    chk("rst_res_data", res_data, 0);
    reset = 0;
    #1 chk("idle_arr_reset", arr_reset, 0);
    @(negedge clk);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        load(0, r*S+c, 8'(r == c), 1);
        load(1, r*S+c, 8'(4*r+c+1), 1);
      end
    run(0, 0, 0, 0);
    last = golden();
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_valid", res_valid, 1);
    chk("hold_data", res_data, last);
    chk("identity_eq_b", res_data, 128'h100f0e0d0c0b0a090807060504030201);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        load(0, r*S+c, 8'(r+c), 1);
        load(1, r*S+c, 8'(r-c+3), 1);
      end
    run(0, 0, 0, 0);
    wait_idle();
    for (int i = 0; i < S*S; i++) begin
      load(0, i, 8'hff, 1);
      load(1, i, 8'hff, 1);
    end
    run(0, 0, 0, 0);
    wait_idle();
    chk("all_ff", res_data, {16{8'h04}});
    load_rand();
    run(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("busy_feed", busy, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_idle();
    load_rand();
    run(0, 0, 0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) load(i % 2, i * 5, 8'($urandom), 0);
    wait_idle();
    last = res_data;
    run(0, 0, 0, 0);
    wait_idle();
    chk("rerun_same", res_data, last);
    run(0, 0, 0, 0);
    repeat (6) @(negedge clk);
    q.delete();
    reset = 1;
    #1;
    chk("midrst_arr_reset", arr_reset, 1);
    chk("midrst_ld_ready", ld_ready, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("postrst_valid", res_valid, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_ld_ready", ld_ready, 1);
    for (int i = 0; i < S*S; i++) begin
      ma[i] = 0; mb[i] = 0;
    end
    @(negedge clk);
    run(0, 0, 0, 0);
    wait_idle();
    for (int j = 0; j < 3; j++) begin
      load_rand();
      run(1, j % 2, int'($urandom_range(0, 15)), 8'($urandom));
      wait_idle();
    end
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
